// File: rtl/core_pkg.sv
// core_pkg: shared core types, opcodes and stage handshake state encoding
package core_pkg;

    typedef enum logic [2:0] {
        T_R    = 3'd0,
        T_I    = 3'd1,
        T_S    = 3'd2,
        T_B    = 3'd3,
        T_U    = 3'd4,
        T_J    = 3'd5,
        T_NONE = 3'd6
    } inst_type_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } stage_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/idu_dec.sv
// idu_dec: combinational RV32I format, register index and immediate decoder
// Ports: inst (raw instruction) in; typ, rs1_id, rs2_id, rd_id, imm, wr_en, illegal out.
module idu_dec
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           inst,
    output logic [2:0]            typ,
    output logic [4:0]            rs1_id,
    output logic [4:0]            rs2_id,
    output logic [4:0]            rd_id,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  wr_en,
    output logic                  illegal
);

    inst_type_t  t;
    logic [31:0] imm32;

    always_comb begin
        t = T_NONE;
        case (inst[6:0])
            OP_R:                                 t = T_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  t = T_I;
            OP_STORE:                             t = T_S;
            OP_BRANCH:                            t = T_B;
            OP_LUI, OP_AUIPC:                     t = T_U;
            OP_JAL:                               t = T_J;
            default:                              t = T_NONE;
        endcase
    end

    always_comb begin
        imm32 = (t == T_I) ? {{20{inst[31]}}, inst[31:20]} :
                (t == T_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                (t == T_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                (t == T_U) ? {inst[31:12], 12'b0} :
                (t == T_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                             32'b0;
    end

    assign typ     = t;
    assign illegal = (t == T_NONE);
    assign rs1_id  = (t inside {T_R, T_I, T_S, T_B}) ? inst[19:15] : 5'd0;
    assign rs2_id  = (t inside {T_R, T_S, T_B})      ? inst[24:20] : 5'd0;
    assign rd_id   = (t inside {T_R, T_I, T_U, T_J}) ? inst[11:7]  : 5'd0;
    assign wr_en   = (t inside {T_R, T_I, T_U, T_J}) && (inst[11:7] != 5'd0) && !illegal;
    assign imm     = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/idu.sv
// idu: decode stage; captures one fetched instruction and hands its decode to execute
// Ports: i_sys_clk/i_sys_rst clock and sync reset; i_ifu_valid/o_idu_ready/i_ifu_pc/i_ifu_inst
// fetch-side handshake; o_idu_valid/i_exu_ready execute-side handshake; o_idu_* decoded payload.
module idu
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_ifu_valid,
    output logic                  o_idu_ready,
    input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
    input  logic [INST_WIDTH-1:0] i_ifu_inst,
    output logic                  o_idu_valid,
    input  logic                  i_exu_ready,
    output logic [ADDR_WIDTH-1:0] o_idu_pc,
    output logic [INST_WIDTH-1:0] o_idu_inst,
    output logic [2:0]            o_idu_type,
    output logic [4:0]            o_idu_rs1_id,
    output logic [4:0]            o_idu_rs2_id,
    output logic [4:0]            o_idu_rd_id,
    output logic [2:0]            o_idu_funct3,
    output logic [6:0]            o_idu_funct7,
    output logic [DATA_WIDTH-1:0] o_idu_imm,
    output logic                  o_idu_wr_en,
    output logic                  o_idu_illegal
);

    stage_state_t state;

    // Handshake outputs are registered alongside the state so they never glitch.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state       <= S_IDLE;
            o_idu_ready <= 1'b1;
            o_idu_valid <= 1'b0;
            o_idu_pc    <= '0;
            o_idu_inst  <= INST_NOP;
        end else begin
            case (state)
                S_IDLE: if (i_ifu_valid) begin
                    state       <= S_WAIT;
                    o_idu_ready <= 1'b0;
                    o_idu_valid <= 1'b1;
                    o_idu_pc    <= i_ifu_pc;
                    o_idu_inst  <= i_ifu_inst;
                end
                S_WAIT: if (i_exu_ready) begin
                    state       <= S_IDLE;
                    o_idu_ready <= 1'b1;
                    o_idu_valid <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    o_idu_ready <= 1'b1;
                    o_idu_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_idu_funct3 = o_idu_inst[14:12];
    assign o_idu_funct7 = o_idu_inst[31:25];

    idu_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .inst    (o_idu_inst[31:0]),
        .typ     (o_idu_type),
        .rs1_id  (o_idu_rs1_id),
        .rs2_id  (o_idu_rs2_id),
        .rd_id   (o_idu_rd_id),
        .imm     (o_idu_imm),
        .wr_en   (o_idu_wr_en),
        .illegal (o_idu_illegal)
    );

endmodule

// File: tb/tb_idu.sv
// tb_idu: scoreboard bench for the decode stage handshakes and RV32I decode
module tb_idu;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ifu_valid = 1'b0;
    logic        i_exu_ready = 1'b0;
    logic [31:0] i_ifu_pc = '0;
    logic [31:0] i_ifu_inst = '0;
    logic        o_idu_ready, o_idu_valid, o_idu_wr_en, o_idu_illegal;
    logic [31:0] o_idu_pc, o_idu_inst, o_idu_imm;
    logic [2:0]  o_idu_type, o_idu_funct3;
    logic [4:0]  o_idu_rs1_id, o_idu_rs2_id, o_idu_rd_id;
    logic [6:0]  o_idu_funct7;
    exp_t        obs, e;
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    idu dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst),
        .i_ifu_valid   (i_ifu_valid),
        .o_idu_ready   (o_idu_ready),
        .i_ifu_pc      (i_ifu_pc),
        .i_ifu_inst    (i_ifu_inst),
        .o_idu_valid   (o_idu_valid),
        .i_exu_ready   (i_exu_ready),
        .o_idu_pc      (o_idu_pc),
        .o_idu_inst    (o_idu_inst),
        .o_idu_type    (o_idu_type),
        .o_idu_rs1_id  (o_idu_rs1_id),
        .o_idu_rs2_id  (o_idu_rs2_id),
        .o_idu_rd_id   (o_idu_rd_id),
        .o_idu_funct3  (o_idu_funct3),
        .o_idu_funct7  (o_idu_funct7),
        .o_idu_imm     (o_idu_imm),
        .o_idu_wr_en   (o_idu_wr_en),
        .o_idu_illegal (o_idu_illegal)
    );

    assign obs = {o_idu_pc, o_idu_inst, o_idu_type, o_idu_rs1_id, o_idu_rs2_id,
                  o_idu_rd_id, o_idu_imm, o_idu_wr_en, o_idu_illegal};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer an instruction until decode is ready, push its expectation, and return
    // #1 after the accept edge with fetch's valid dropped.
    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input exp_t x);
        i_ifu_pc    = pc;
        i_ifu_inst  = inst;
        i_ifu_valid = 1'b1;
        for (int k = 0; k < 20 && !o_idu_ready; k++) step();
        n_vec++;
        if (o_idu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout ready=%b required 1", o_idu_ready);
        end else sb.push_back(x);
        step();
        i_ifu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec += 6;
        if (o_idu_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", o_idu_valid); end
        if (o_idu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", o_idu_ready); end
        if (o_idu_inst !== 32'h00000013) begin n_bad++; $display("FAIL rst_inst got %h want 00000013", o_idu_inst); end
        if (o_idu_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b want 0", o_idu_wr_en); end
        if (o_idu_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", o_idu_pc); end
        if ({o_idu_type, o_idu_imm, o_idu_illegal} !== {T_I, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_decode got type=%0d imm=%h ill=%b want type=1 imm=0 ill=0",
                     o_idu_type, o_idu_imm, o_idu_illegal);
        end
    endtask

    task automatic test_basic_i();
        i_exu_ready = 1'b1;
        offer(32'h80000000, 32'hFFF30293,
              '{32'h80000000, 32'hFFF30293, T_I, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0});
        n_vec += 3;
        if (o_idu_valid !== 1'b1) begin n_bad++; $display("FAIL addi_latency valid=%b want 1", o_idu_valid); end
        e = sb.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL addi_payload got %h want %h", obs, e); end
        if ({o_idu_funct3, o_idu_funct7} !== {3'b000, 7'h7F}) begin
            n_bad++;
            $display("FAIL addi_funct got %h/%h want 0/7f", o_idu_funct3, o_idu_funct7);
        end
        step();
        n_vec++;
        if ({o_idu_valid, o_idu_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL addi_release valid/ready=%b%b want 01", o_idu_valid, o_idu_ready);
        end
    endtask

    task automatic test_backpressure();
        i_exu_ready = 1'b0;
        offer(32'h00000100, 32'h0020A423,
              '{32'h00000100, 32'h0020A423, T_S, 5'd1, 5'd2, 5'd0, 32'h00000008, 1'b0, 1'b0});
        i_ifu_pc    = 32'h00000200;
        i_ifu_inst  = 32'h00000013;
        i_ifu_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_vec += 2;
            if (obs !== sb[0]) begin n_bad++; $display("FAIL sw_stable[%0d] got %h want %h", c, obs, sb[0]); end
            if ({o_idu_valid, o_idu_ready} !== 2'b10) begin
                n_bad++;
                $display("FAIL sw_hold[%0d] valid/ready=%b%b want 10", c, o_idu_valid, o_idu_ready);
            end
            step();
        end
        // Execute takes it while fetch is still offering: only the handoff completes.
        i_exu_ready = 1'b1;
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL sw_payload got %h want %h", obs, e); end
        sb.push_back('{32'h00000200, 32'h00000013, T_I, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0});
        step();
        n_vec += 2;
        if ({o_idu_valid, o_idu_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL sw_handoff valid/ready=%b%b want 01", o_idu_valid, o_idu_ready);
        end
        if (o_idu_inst !== 32'h0020A423) begin n_bad++; $display("FAIL sw_no_capture got %h want 0020a423", o_idu_inst); end
        step();
        i_ifu_valid = 1'b0;
        e = sb.pop_front();
        n_vec += 2;
        if (o_idu_valid !== 1'b1) begin n_bad++; $display("FAIL nop_valid got %b want 1", o_idu_valid); end
        if (obs !== e) begin n_bad++; $display("FAIL nop_payload got %h want %h", obs, e); end
        step();
    endtask

    task automatic test_j_u();
        i_exu_ready = 1'b1;
        offer(32'h00001000, 32'hFFDFF0EF,
              '{32'h00001000, 32'hFFDFF0EF, T_J, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFC, 1'b1, 1'b0});
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL jal_payload got %h want %h", obs, e); end
        step();
        offer(32'h00001004, 32'h12345537,
              '{32'h00001004, 32'h12345537, T_U, 5'd0, 5'd0, 5'd10, 32'h12345000, 1'b1, 1'b0});
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin n_bad++; $display("FAIL lui_payload got %h want %h", obs, e); end
        step();
    endtask

    task automatic test_illegal_and_reset();
        i_exu_ready = 1'b1;
        offer(32'h00002000, 32'hFFFFFFFF,
              '{32'h00002000, 32'hFFFFFFFF, T_NONE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1});
        e = sb.pop_front();
        // Immediate is unspecified for an unsupported encoding, so it is left out here.
        n_vec += 3;
        if ({o_idu_valid, o_idu_illegal, o_idu_wr_en} !== 3'b110) begin
            n_bad++;
            $display("FAIL ill_flags valid/ill/wr=%b%b%b want 110", o_idu_valid, o_idu_illegal, o_idu_wr_en);
        end
        if ({o_idu_type, o_idu_rs1_id, o_idu_rs2_id, o_idu_rd_id} !== {e.typ, e.rs1, e.rs2, e.rd}) begin
            n_bad++;
            $display("FAIL ill_fields type=%0d rs1=%0d rs2=%0d rd=%0d want type=6 all 0",
                     o_idu_type, o_idu_rs1_id, o_idu_rs2_id, o_idu_rd_id);
        end
        if ({o_idu_pc, o_idu_inst} !== {e.pc, e.inst}) begin
            n_bad++;
            $display("FAIL ill_capture got %h/%h want %h/%h", o_idu_pc, o_idu_inst, e.pc, e.inst);
        end
        step();
        n_vec++;
        if ({o_idu_valid, o_idu_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL ill_handoff valid/ready=%b%b want 01", o_idu_valid, o_idu_ready);
        end
        i_exu_ready = 1'b0;
        offer(32'h00003000, 32'h12345537,
              '{32'h00003000, 32'h12345537, T_U, 5'd0, 5'd0, 5'd10, 32'h12345000, 1'b1, 1'b0});
        n_vec++;
        if (o_idu_valid !== 1'b1) begin n_bad++; $display("FAIL wait_entry valid=%b want 1", o_idu_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        n_vec += 3;
        if ({o_idu_valid, o_idu_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_wait valid/ready=%b%b want 01", o_idu_valid, o_idu_ready);
        end
        if ({o_idu_pc, o_idu_inst} !== {32'h0, 32'h00000013}) begin
            n_bad++;
            $display("FAIL rst_wait_regs got %h/%h want 0/00000013", o_idu_pc, o_idu_inst);
        end
        if ({o_idu_rd_id, o_idu_wr_en} !== 6'd0) begin
            n_bad++;
            $display("FAIL rst_wait_decode rd=%0d wr=%b want 0/0", o_idu_rd_id, o_idu_wr_en);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_i();
        test_backpressure();
        test_j_u();
        test_illegal_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
